// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel coordinate path.
//   KTAPS / KIDX_W : 3x3 kernel tap count and tap-index width.
//   tap_dx/tap_dy  : kernel tap index k -> signed neighbour offsets.
//   scan_state_t   : scanner FSM encoding (IDLE/SCAN/DONE).
//   coord_bits     : coordinate width helper, also used by the address generator.
package sobel_pkg;

    localparam int KTAPS  = 9;
    localparam int KIDX_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SCAN = ST_SCAN,
        DONE = ST_DONE
    } scan_state_t;

    // Row offset: taps 0..2 sit one row above the centre, 6..8 one row below.
    function automatic logic signed [1:0] tap_dx(input logic [KIDX_W-1:0] k);
        if (k < 4'd3) begin
            return -2'sd1;
        end else if (k < 4'd6) begin
            return 2'sd0;
        end
        return 2'sd1;
    endfunction

    // Column offset: k mod 3, shifted to -1..+1.
    function automatic logic signed [1:0] tap_dy(input logic [KIDX_W-1:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: return -2'sd1;
            4'd1, 4'd4, 4'd7: return 2'sd0;
            default:          return 2'sd1;
        endcase
    endfunction

    function automatic int coord_bits(input int size);
        return $clog2(size);
    endfunction

endpackage

// File: rtl/sobel_tap_offset.sv
// Combinational kernel tap decoder: tap index -> signed (dx, dy) offsets.
//   i_k  : tap index 0..8
//   o_dx : signed row offset    -1..+1
//   o_dy : signed column offset -1..+1
module sobel_tap_offset
    import sobel_pkg::*;
(
    input  logic [KIDX_W-1:0] i_k,
    output logic signed [1:0] o_dx,
    output logic signed [1:0] o_dy
);

    assign o_dx = tap_dx(i_k);
    assign o_dy = tap_dy(i_k);

endmodule

// File: rtl/sobel_window_scanner.sv
// Walks every interior centre pixel of an X_SIZE x Y_SIZE image and emits the
// nine 3x3 neighbour coordinates of each window, one per accepted beat.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   Start_i            : begin a frame scan (only honoured in IDLE)
//   Ready_i            : downstream accepts the current beat
//   Valid_o            : beat outputs are valid
//   X_o, Y_o, KIdx_o   : neighbour coordinate and kernel tap index
//   WinLast_o          : tap 8 of a window
//   FrameLast_o        : tap 8 of the final window
//   Busy_o             : scan in progress
//   Done_o             : one-cycle pulse after the final beat is accepted
module sobel_window_scanner
    import sobel_pkg::*;
#(
    parameter int X_SIZE = 100,
    parameter int Y_SIZE = 100
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      Start_i,
    input  logic                      Ready_i,
    output logic                      Valid_o,
    output logic [$clog2(X_SIZE)-1:0] X_o,
    output logic [$clog2(Y_SIZE)-1:0] Y_o,
    output logic [3:0]                KIdx_o,
    output logic                      WinLast_o,
    output logic                      FrameLast_o,
    output logic                      Busy_o,
    output logic                      Done_o
);

    localparam int X_W = coord_bits(X_SIZE);
    localparam int Y_W = coord_bits(Y_SIZE);

    localparam logic [X_W-1:0]    CX_FIRST = X_W'(1);
    localparam logic [X_W-1:0]    CX_LAST  = X_W'(X_SIZE - 2);
    localparam logic [Y_W-1:0]    CY_FIRST = Y_W'(1);
    localparam logic [Y_W-1:0]    CY_LAST  = Y_W'(Y_SIZE - 2);
    localparam logic [KIDX_W-1:0] K_ONE    = KIDX_W'(1);
    localparam logic [KIDX_W-1:0] K_LAST   = KIDX_W'(KTAPS - 1);

    scan_state_t         r_state, w_state_next;
    logic [X_W-1:0]      r_cx, w_cx_next;
    logic [Y_W-1:0]      r_cy, w_cy_next;
    logic [KIDX_W-1:0]   r_k, w_k_next;

    logic                r_valid;
    logic                r_win_last;
    logic                r_frame_last;
    logic                r_done;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;

    logic                w_last_centre;
    logic                w_next_scan;
    logic                w_next_win_last;
    logic signed [1:0]   w_dx, w_dy;
    logic [X_W:0]        w_x_sum;
    logic [Y_W:0]        w_y_sum;
    logic                w_unused;

    // Offsets are decoded from the *next* tap so the coordinate outputs can be
    // registered in the same cycle the counters advance.
    sobel_tap_offset u_tap_offset (
        .i_k  (w_k_next),
        .o_dx (w_dx),
        .o_dy (w_dy)
    );

    // One guard bit on the adders; centre +/- 1 always lands inside the image,
    // so the guard bit is never needed in the output.
    assign w_x_sum  = {1'b0, w_cx_next} + {{(X_W-1){w_dx[1]}}, w_dx};
    assign w_y_sum  = {1'b0, w_cy_next} + {{(Y_W-1){w_dy[1]}}, w_dy};
    assign w_unused = w_x_sum[X_W] ^ w_y_sum[Y_W];

    always_comb begin
        w_state_next  = r_state;
        w_cx_next     = r_cx;
        w_cy_next     = r_cy;
        w_k_next      = r_k;
        w_last_centre = (r_cx == CX_LAST) && (r_cy == CY_LAST);

        case (r_state)
            IDLE: begin
                if (Start_i) begin
                    w_state_next = SCAN;
                    w_cx_next    = CX_FIRST;
                    w_cy_next    = CY_FIRST;
                    w_k_next     = '0;
                end
            end
            SCAN: begin
                // Valid is always high in SCAN, so Ready_i alone means a transfer.
                if (Ready_i) begin
                    if (r_k != K_LAST) begin
                        w_k_next = r_k + K_ONE;
                    end else begin
                        w_k_next = '0;
                        if (w_last_centre) begin
                            w_state_next = DONE;
                            w_cx_next    = CX_FIRST;
                            w_cy_next    = CY_FIRST;
                        end else if (r_cy != CY_LAST) begin
                            w_cy_next = r_cy + CY_FIRST;
                        end else begin
                            w_cy_next = CY_FIRST;
                            w_cx_next = r_cx + CX_FIRST;
                        end
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_next_scan     = (w_state_next == SCAN);
    assign w_next_win_last = w_next_scan && (w_k_next == K_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_cx         <= CX_FIRST;
            r_cy         <= CY_FIRST;
            r_k          <= '0;
            r_valid      <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_win_last   <= 1'b0;
            r_frame_last <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cx         <= w_cx_next;
            r_cy         <= w_cy_next;
            r_k          <= w_k_next;
            r_valid      <= w_next_scan;
            r_x          <= w_x_sum[X_W-1:0];
            r_y          <= w_y_sum[Y_W-1:0];
            r_win_last   <= w_next_win_last;
            r_frame_last <= w_next_win_last && (w_cx_next == CX_LAST) && (w_cy_next == CY_LAST);
            r_done       <= (w_state_next == DONE);
        end
    end

    assign Valid_o     = r_valid;
    assign Busy_o      = r_valid;   // SCAN is exactly the window where beats are valid
    assign X_o         = r_x;
    assign Y_o         = r_y;
    assign KIdx_o      = r_k;
    assign WinLast_o   = r_win_last;
    assign FrameLast_o = r_frame_last;
    assign Done_o      = r_done;

endmodule
